// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, H/V counters and a
// single registered decode stage driving sync, data-enable, coordinates, strobes and blanked colour.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic [COLOR_W-1:0] vga_red,
    output logic [COLOR_W-1:0] vga_green,
    output logic [COLOR_W-1:0] vga_blue
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Region bounds are compared one bit wider so an active region ending exactly at
    // the total count (zero front porch) still fits.
    localparam int CW = COORD_W + 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] CNT_ONE   = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_OFFSET  = COORD_W'(H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] V_OFFSET  = COORD_W'(V_SYNC + V_BP);
    localparam logic [CW-1:0]      H_SYNC_E  = CW'(H_SYNC);
    localparam logic [CW-1:0]      V_SYNC_E  = CW'(V_SYNC);
    localparam logic [CW-1:0]      H_ACT_S   = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0]      H_ACT_E   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0]      V_ACT_S   = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0]      V_ACT_E   = CW'(V_SYNC + V_BP + V_ACTIVE);

    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               tick;

    logic [CW-1:0]      h_ext;
    logic [CW-1:0]      v_ext;
    logic               h_act;
    logic               v_act;
    logic               de_d;
    logic               line_d;
    logic               frame_d;
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_d;

    assign tick = en && (div_cnt == DIV_LAST);

    // With CLK_DIV=1 the divider sits at zero and tick follows en directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
                end else begin
                    h_cnt <= h_cnt + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        h_ext   = {1'b0, h_cnt};
        v_ext   = {1'b0, v_cnt};
        h_act   = (h_ext >= H_ACT_S) && (h_ext < H_ACT_E);
        v_act   = (v_ext >= V_ACT_S) && (v_ext < V_ACT_E);
        de_d    = h_act && v_act;
        x_d     = de_d ? (h_cnt - H_OFFSET) : '0;
        y_d     = de_d ? (v_cnt - V_OFFSET) : '0;
        // Only the first divider phase of pixel 0 qualifies, so a strobe fires once per line.
        line_d  = en && (div_cnt == '0) && (h_cnt == '0);
        frame_d = line_d && (v_cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
        end else begin
            h_sync      <= (h_ext < H_SYNC_E) ? H_POL : ~H_POL;
            v_sync      <= (v_ext < V_SYNC_E) ? V_POL : ~V_POL;
            de          <= de_d;
            x           <= x_d;
            y           <= y_d;
            line_start  <= line_d;
            frame_start <= frame_d;
            vga_red     <= de_d ? red_in   : '0;
            vga_green   <= de_d ? green_in : '0;
            vga_blue    <= de_d ? blue_in  : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: two small rasters (CLK_DIV=1 active-high syncs,
// CLK_DIV=2 active-low syncs) with hand-computed counts, positions, freeze and reset behaviour.
module tb_vga_timing_gen;

    logic       clk;
    logic       reset;
    logic       en_a;
    logic       en_b;
    logic [1:0] red_in;
    logic [1:0] green_in;
    logic [1:0] blue_in;

    logic       h_sync_a, v_sync_a, de_a, line_start_a, frame_start_a;
    logic [3:0] x_a, y_a;
    logic [1:0] vga_red_a, vga_green_a, vga_blue_a;
    logic       h_sync_b, v_sync_b, de_b, line_start_b, frame_start_b;
    logic [3:0] x_b, y_b;
    logic [1:0] vga_red_b, vga_green_b, vga_blue_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fs_a = 0;
    int fs_per_a = 0;
    int last_fs_b = 0;
    int fs_per_b = 0;

    // A: line 8 px (sync 0-1, bp 2, active 3-6, fp 7), frame 6 lines (sync 0, bp 1, active 2-4, fp 5)
    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .H_POL(1'b1), .V_POL(1'b1), .COORD_W(4), .COLOR_W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en_a),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .h_sync(h_sync_a), .v_sync(v_sync_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(line_start_a), .frame_start(frame_start_a),
        .vga_red(vga_red_a), .vga_green(vga_green_a), .vga_blue(vga_blue_a)
    );

    // B: line 12 px (sync 0-2, bp 3-4, active 5-9, fp 10-11), frame 7 lines (sync 0-1, bp 2, active 3-5, fp 6)
    vga_timing_gen #(
        .CLK_DIV(2), .H_SYNC(3), .H_BP(2), .H_ACTIVE(5), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .H_POL(1'b0), .V_POL(1'b0), .COORD_W(4), .COLOR_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en_b),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .h_sync(h_sync_b), .v_sync(v_sync_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(line_start_b), .frame_start(frame_start_b),
        .vga_red(vga_red_b), .vga_green(vga_green_b), .vga_blue(vga_blue_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_start_a === 1'b1) begin
            fs_per_a  <= cyc - last_fs_a;
            last_fs_a <= cyc;
        end
        if (frame_start_b === 1'b1) begin
            fs_per_b  <= cyc - last_fs_b;
            last_fs_b <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int de_a_n, hs_a_n, vs_a_n, ls_a_n, fs_a_n, xs_a, ys_a, bad_a;
        int first_a, last_a, fx_a, fy_a, lx_a, ly_a;
        int de_b_n, hs_b_n, vs_b_n, ls_b_n, fs_b_n, xs_b, ys_b, bad_b;
        int first_b, last_b, fx_b, fy_b, lx_b, ly_b;
        int frozen_bad;
        bit found;

        de_a_n = 0; hs_a_n = 0; vs_a_n = 0; ls_a_n = 0; fs_a_n = 0; xs_a = 0; ys_a = 0; bad_a = 0;
        first_a = 0; last_a = 0; fx_a = 0; fy_a = 0; lx_a = 0; ly_a = 0;
        de_b_n = 0; hs_b_n = 0; vs_b_n = 0; ls_b_n = 0; fs_b_n = 0; xs_b = 0; ys_b = 0; bad_b = 0;
        first_b = 0; last_b = 0; fx_b = 0; fy_b = 0; lx_b = 0; ly_b = 0;

        reset    = 1'b1;
        en_a     = 1'b1;
        en_b     = 1'b1;
        red_in   = 2'b11;
        green_in = 2'b10;
        blue_in  = 2'b01;

        repeat (3) @(negedge clk);
        check("rst_a_hsync", h_sync_a, 0);
        check("rst_a_vsync", v_sync_a, 0);
        check("rst_b_hsync", h_sync_b, 1);
        check("rst_b_vsync", v_sync_b, 1);
        check("rst_de", {de_a, de_b}, 0);
        check("rst_xy", {x_a, y_a, x_b, y_b}, 0);
        check("rst_strobes", {line_start_a, frame_start_a, line_start_b, frame_start_b}, 0);
        check("rst_vga", {vga_red_a, vga_green_a, vga_blue_a, vga_red_b, vga_green_b, vga_blue_b}, 0);

        reset = 1'b0;

        // One full frame of each raster plus the wrap into the next.
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            if (k <= 48) begin
                if (de_a) de_a_n++;
                if (h_sync_a) hs_a_n++;
                if (v_sync_a) vs_a_n++;
                if (line_start_a) ls_a_n++;
                if (frame_start_a) fs_a_n++;
                if (de_a) begin
                    if (first_a == 0) begin first_a = k; fx_a = x_a; fy_a = y_a; end
                    last_a = k; lx_a = x_a; ly_a = y_a;
                    xs_a += x_a; ys_a += y_a;
                end else if (x_a != 0 || y_a != 0) bad_a++;
                if (vga_red_a !== (de_a ? red_in : 2'b00) || vga_green_a !== (de_a ? green_in : 2'b00)
                    || vga_blue_a !== (de_a ? blue_in : 2'b00)) bad_a++;
            end
            if (k <= 168) begin
                if (de_b) de_b_n++;
                if (!h_sync_b) hs_b_n++;
                if (!v_sync_b) vs_b_n++;
                if (line_start_b) ls_b_n++;
                if (frame_start_b) fs_b_n++;
                if (de_b) begin
                    if (first_b == 0) begin first_b = k; fx_b = x_b; fy_b = y_b; end
                    last_b = k; lx_b = x_b; ly_b = y_b;
                    xs_b += x_b; ys_b += y_b;
                end else if (x_b != 0 || y_b != 0) bad_b++;
                if (vga_red_b !== (de_b ? red_in : 2'b00) || vga_green_b !== (de_b ? green_in : 2'b00)
                    || vga_blue_b !== (de_b ? blue_in : 2'b00)) bad_b++;
            end
            if (k == 1) begin
                check("first_a_strobes_sync", {line_start_a, frame_start_a, h_sync_a, v_sync_a}, 4'b1111);
                check("first_b_strobes_sync", {line_start_b, frame_start_b, h_sync_b, v_sync_b}, 4'b1100);
            end
            if (k == 49) check("a_frame_wrap", {frame_start_a, line_start_a}, 2'b11);
            if (k == 168) check("b_pre_wrap_sync", {v_sync_b, h_sync_b, frame_start_b}, 3'b110);
            if (k == 169) check("b_wrap_pulse", {line_start_b, frame_start_b, h_sync_b, v_sync_b}, 4'b1100);
            if (k == 170) check("b_wrap_pulse_end", {line_start_b, frame_start_b}, 2'b00);
            red_in   = 2'(k);
            green_in = 2'(k >> 1);
            blue_in  = ~2'(k);
        end
        #1;

        check("a_de_count", de_a_n, 12);
        check("a_hsync_count", hs_a_n, 12);
        check("a_vsync_count", vs_a_n, 8);
        check("a_line_count", ls_a_n, 6);
        check("a_frame_count", fs_a_n, 1);
        check("a_first_de", {first_a[7:0], fx_a[3:0], fy_a[3:0]}, {8'd20, 4'd0, 4'd0});
        check("a_last_de", {last_a[7:0], lx_a[3:0], ly_a[3:0]}, {8'd39, 4'd3, 4'd2});
        check("a_xy_sums", {xs_a[15:0], ys_a[15:0]}, {16'd18, 16'd12});
        check("a_blank_bad", bad_a, 0);
        check("a_frame_period", fs_per_a, 48);
        check("b_de_count", de_b_n, 30);
        check("b_hsync_low", hs_b_n, 42);
        check("b_vsync_low", vs_b_n, 48);
        check("b_line_count", ls_b_n, 7);
        check("b_frame_count", fs_b_n, 1);
        check("b_first_de", {first_b[7:0], fx_b[3:0], fy_b[3:0]}, {8'd83, 4'd0, 4'd0});
        check("b_last_de", {last_b[7:0], lx_b[3:0], ly_b[3:0]}, {8'd140, 4'd4, 4'd2});
        check("b_xy_sums", {xs_b[15:0], ys_b[15:0]}, {16'd60, 16'd30});
        check("b_blank_bad", bad_b, 0);
        check("b_frame_period", fs_per_b, 168);

        // Freeze A for 37 clks in the middle of an active line (row y=1).
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (de_a && x_a == 4'd1 && y_a == 4'd1) found = 1'b1;
        end
        check("freeze_find_timeout", found, 1);
        en_a = 1'b0;
        frozen_bad = 0;
        repeat (37) begin
            @(negedge clk);
            if ({de_a, x_a, y_a, h_sync_a, v_sync_a, line_start_a, frame_start_a} !== {1'b1, 4'd2, 4'd1, 4'b0000})
                frozen_bad++;
            if (vga_red_a !== red_in || vga_green_a !== green_in || vga_blue_a !== blue_in) frozen_bad++;
        end
        check("freeze_held_outputs", frozen_bad, 0);
        en_a = 1'b1;
        @(negedge clk);
        check("resume_x_held", {de_a, x_a}, {1'b1, 4'd2});
        @(negedge clk);
        check("resume_x_next", {de_a, x_a}, {1'b1, 4'd3});
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (frame_start_a) found = 1'b1;
        end
        #1;
        check("freeze_fs_timeout", found, 1);
        check("freeze_frame_period", fs_per_a, 85);

        // Reset B mid-frame on active row y=1.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (de_b && y_b == 4'd1) found = 1'b1;
        end
        check("reset_find_timeout", found, 1);
        reset = 1'b1;
        #1;
        check("async_rst_b", {de_b, x_b, y_b, h_sync_b, v_sync_b, line_start_b, frame_start_b},
              {1'b0, 4'd0, 4'd0, 4'b1100});
        check("async_rst_b_vga", {vga_red_b, vga_green_b, vga_blue_b}, 0);
        check("async_rst_a", {de_a, h_sync_a, v_sync_a}, 0);
        en_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold_strobes", {line_start_a, frame_start_a, line_start_b, frame_start_b, de_a, de_b}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_a_strobes", {line_start_a, frame_start_a, h_sync_a}, 3'b111);
        check("rel_b_en_low", {line_start_b, frame_start_b, h_sync_b, v_sync_b}, 4'b0000);
        repeat (2) @(negedge clk);
        check("rel_b_still_held", {line_start_b, frame_start_b, h_sync_b, de_b}, 4'b0000);
        en_b = 1'b1;
        @(negedge clk);
        check("rel_b_first_en", {line_start_b, frame_start_b}, 2'b11);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (frame_start_b) found = 1'b1;
        end
        #1;
        check("rel_b_fs_timeout", found, 1);
        check("rel_b_frame_period", fs_per_b, 168);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator.
- Replaces the fixed 640x480 split H/V sync pair with one block that has configurable porch, sync and active widths, sync polarity, and pixel-clock division.
- Generates h_sync, v_sync, data-enable, pixel coordinates, line/frame strobes, and blanks the incoming colour to the VGA pins.
- Sits between the pixel-source logic and the board VGA connector.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (>=1)
- H_SYNC, 96, h sync width in pixels
- H_BP, 48, h back porch in pixels
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, h front porch in pixels
- V_SYNC, 2, v sync width in lines
- V_BP, 29, v back porch in lines
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, v front porch in lines
- H_POL, 0, asserted level of h_sync
- V_POL, 0, asserted level of v_sync
- COORD_W, 10, width of counters and coordinates; must hold H_TOTAL-1 and V_TOTAL-1
- COLOR_W, 1, bits per colour channel

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- en  in  1  timing advance enable; low freezes the raster
- red_in  in  COLOR_W  pixel colour from source
- green_in  in  COLOR_W  pixel colour from source
- blue_in  in  COLOR_W  pixel colour from source
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- de  out  1  active-video flag
- x  out  COORD_W  active pixel column
- y  out  COORD_W  active pixel row
- line_start  out  1  one-clk strobe at start of each line
- frame_start  out  1  one-clk strobe at start of each frame
- vga_red  out  COLOR_W  blanked colour to pin
- vga_green  out  COLOR_W  blanked colour to pin
- vga_blue  out  COLOR_W  blanked colour to pin

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
- Line order and frame order are both SYNC, BP, ACTIVE, FP, starting at count 0.
- Divider: div_cnt counts 0..CLK_DIV-1 on clk when en=1.
  - tick = en && div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, tick = en.
- h_cnt: on tick, increments; wraps H_TOTAL-1 -> 0.
- v_cnt: on tick with h wrap, increments; wraps V_TOTAL-1 -> 0.
- Counter updates are simultaneous, so (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in one tick.
- en=0: div_cnt, h_cnt and v_cnt hold. Registered outputs keep re-evaluating the held counts. Strobes are 0.
- Output stage: every clk, all outputs register a decode of the current (h_cnt, v_cnt) and the current colour inputs. Fixed latency of 1 clk from counter/colour to pins. No other pipelining.
  - h_sync = H_POL when h_cnt < H_SYNC, else ~H_POL.
  - v_sync = V_POL when v_cnt < V_SYNC, else ~V_POL.
  - de = 1 iff H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE AND V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
  - x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) when de, else 0.
  - vga_* = *_in when de, else 0.
- line_start = 1 for one clk: registered from (en && div_cnt==0 && h_cnt==0).
- frame_start = line_start condition AND v_cnt==0.
- Each strobe fires once per line/frame for any CLK_DIV.
- Reset values (async):
  - div_cnt=h_cnt=v_cnt=0.
  - h_sync=~H_POL, v_sync=~V_POL.
  - de=0, x=y=0, line_start=frame_start=0, vga_*=0.
- After reset deasserts with en=1: first clk registers sync asserted and line_start=frame_start=1.
- Reset mid-frame: immediate return to the reset values above. The frame restarts from (0,0); no partial-line recovery.
- Defaults with 50 MHz clk:
  - line = 1600 clks; frame = 521 lines = 833600 clks.
  - h_sync low 192 clks; v_sync low 3200 clks.
  - active lines 31..510.

Test Plan:
- Defaults, en=1, colour inputs all 1: h_sync period 1600 clks, low 192. v_sync period 833600, low 3200. frame_start every 833600 clks, line_start every 1600.
- Defaults, one full frame: de high exactly 614400 clks. First de 1 clk after h_cnt=144, v_cnt=31, with x=0,y=0. Last de has x=639,y=479. vga_* = 0 whenever de=0.
- CLK_DIV=1, H 2/1/4/1, V 1/1/3/1, H_POL=V_POL=1: line 8 clks, frame 48 clks. h_sync high 2 clks/line. x steps 0..3 on rows 0..2. Sync polarity inverted vs defaults.
- Toggle en low for 37 clks mid active line: all outputs frozen at held values, strobes 0. Resume continues x from the held value; frame period extends by exactly 37 clks.
- Assert reset at v_cnt=200: within the same clk, outputs go to reset values. After release, frame_start on the first en clk, and the next frame_start after exactly 833600 clks.
- Wrap check: observe (h,v)=(799,520) -> next pixel (0,0). frame_start and line_start pulse together for 1 clk only, with CLK_DIV=2.
